regfile_arbiter: RTL and testbench
==================================

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 clk  input  1  clock; all state changes on posedge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
REQ-004 wb_req  input  1  write-back request; held with wb_addr/wb_data until wb_ack.
REQ-005 wb_addr  input  5  destination register index.
REQ-006 wb_data  input  32  write-back data.
REQ-007 wb_ack  output  1  one-cycle pulse: write granted.
REQ-008 rd_req  input  1  decode read request; held with rd_addr1/rd_addr2 until rd_ack.
REQ-009 rd_addr1, rd_addr2  input  5 each  source register indices.
REQ-010 rd_ack  output  1  one-cycle pulse: read granted.
REQ-011 rd_valid  output  1  one-cycle pulse: rd_data1/rd_data2 valid.
REQ-012 rd_data1, rd_data2  output  32 each  captured read data, held until next rd_valid.
REQ-013 rf_wr  output  1  drives register-file write enable (file acts on negedge clk).
REQ-014 rf_waddr, rf_addr1, rf_addr2  output  5 each  register-file write/read indices.
REQ-015 rf_din  output  32  register-file write data.
REQ-016 rf_out_1, rf_out_2  input  32 each  register-file read data, updated on negedge clk when rf_wr=0.
REQ-017 busy  output  1  high in WR or RD state.

Function
REQ-018 FSM states SHALL be IDLE, WR, RD; all outputs registered (Moore).
REQ-019 IDLE: wb_req=1 -> WR; else rd_req=1 -> RD; else IDLE (write priority).
REQ-020 WR: rd_req=1 -> RD; else IDLE; wb_req ignored on the edge leaving WR (no re-grant of the same request).
REQ-021 RD: wb_req=1 -> WR; else IDLE; rd_req ignored on the edge leaving RD.
REQ-022 On entry to WR: wb_ack=1, rf_waddr=wb_addr, rf_din=wb_data, rf_wr=1 unless wb_addr=0, for exactly that cycle.
REQ-023 Write to index 0 SHALL still grant (WR state, wb_ack pulse) but keep rf_wr=0.
REQ-024 On entry to RD: rd_ack=1, rf_addr1=rd_addr1, rf_addr2=rd_addr2, rf_wr=0.
REQ-025 On the posedge ending an RD cycle: rd_data1/rd_data2 <= rf_out_1/rf_out_2, rd_valid=1 for the following cycle; read latency = 2 cycles from rd_ack rising to rd_valid rising.
REQ-026 A read index of 0 SHALL return 0 in the corresponding rd_data regardless of rf_out.
REQ-027 rf_wr SHALL be 0 in IDLE and RD; rf_addr1/rf_addr2/rf_waddr/rf_din hold last values outside grant cycles.
REQ-028 Simultaneous wb_req and rd_req in IDLE: WR then RD on consecutive cycles; read sees the new value if addresses match.
REQ-029 Sustained wb_req and rd_req SHALL alternate WR/RD every cycle; neither requester starves.
REQ-030 rd_valid of a read MAY coincide with a WR or RD cycle of a later grant.

Reset
REQ-031 rst_n=0 at posedge: state=IDLE; wb_ack, rd_ack, rd_valid, rf_wr, busy=0; rd_data1/2, rf_din=0; rf_waddr, rf_addr1, rf_addr2=0.
REQ-032 Reset asserted in a WR cycle: the file's negedge write in that cycle still occurs; no further writes after the reset edge.
REQ-033 Reset asserted in an RD cycle: the pending rd_valid SHALL be suppressed; rd_data stays 0.
REQ-034 Requests held across reset deassertion SHALL be granted per REQ-019 from the first posedge with rst_n=1.

Verification
REQ-035 Write wb_addr=5, wb_data=0xDEADBEEF, then read rd_addr1=5 -> wb_ack 1 cycle, rf_wr 1 cycle, rd_data1=0xDEADBEEF with rd_valid 2 cycles after rd_ack.
REQ-036 wb_req and rd_req rise together (wb_addr=rd_addr1=7, data 0x12345678) -> WR then RD back-to-back, rd_data1=0x12345678.
REQ-037 Write 0xFFFFFFFF to index 0, read index 0 -> wb_ack pulses, rf_wr stays 0, rd_data1=0.
REQ-038 Both requests held high 8 cycles -> state alternates WR,RD,WR,RD...; 4 wb_ack and 4 rd_ack pulses.
REQ-039 rst_n low during RD cycle -> no rd_valid, all outputs 0 next cycle, state IDLE.
REQ-040 No requests for 10 cycles -> busy, rf_wr, wb_ack, rd_ack, rd_valid remain 0.

Source files
------------

// File: rtl/regfile_arbiter.sv
// Arbitrates write-back and decode-read access to a negedge-clocked register file.
// Writes win ties; sustained contention alternates WR/RD; read data lands two cycles after rd_ack.
module regfile_arbiter (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        wb_req_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] wb_data_i,
    output logic        wb_ack_o,
    input  logic        rd_req_i,
    input  logic [4:0]  rd_addr1_i,
    input  logic [4:0]  rd_addr2_i,
    output logic        rd_ack_o,
    output logic        rd_valid_o,
    output logic [31:0] rd_data1_o,
    output logic [31:0] rd_data2_o,
    output logic        rf_wr_o,
    output logic [4:0]  rf_waddr_o,
    output logic [4:0]  rf_addr1_o,
    output logic [4:0]  rf_addr2_o,
    output logic [31:0] rf_din_o,
    input  logic [31:0] rf_out_1_i,
    input  logic [31:0] rf_out_2_i,
    output logic        busy_o
);

    // state | meaning
    // IDLE  | no grant this cycle
    // WR    | write granted; file writes on this cycle's negedge (unless index 0)
    // RD    | read granted; file drives rf_out on this cycle's negedge
    typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2} state_t;

    state_t      state_q, state_d;
    logic        wb_ack_q, wb_ack_d;
    logic        rd_ack_q, rd_ack_d;
    logic        rf_wr_q, rf_wr_d;
    logic        busy_q, busy_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [4:0]  rf_addr1_q, rf_addr1_d;
    logic [4:0]  rf_addr2_q, rf_addr2_d;
    logic [31:0] rf_din_q, rf_din_d;
    logic        stage_vld_q, stage_vld_d;
    logic [31:0] stage1_q, stage1_d;
    logic [31:0] stage2_q, stage2_d;
    logic        rd_valid_q, rd_valid_d;
    logic [31:0] rd_data1_q, rd_data1_d;
    logic [31:0] rd_data2_q, rd_data2_d;

    always_comb begin
        state_d     = state_q;
        wb_ack_d    = 1'b0;
        rd_ack_d    = 1'b0;
        rf_wr_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_addr1_d  = rf_addr1_q;
        rf_addr2_d  = rf_addr2_q;
        rf_din_d    = rf_din_q;
        stage_vld_d = 1'b0;
        stage1_d    = stage1_q;
        stage2_d    = stage2_q;
        rd_valid_d  = stage_vld_q;
        rd_data1_d  = rd_data1_q;
        rd_data2_d  = rd_data2_q;

        case (state_q)
            IDLE:    if (wb_req_i) state_d = WR;
                     else if (rd_req_i) state_d = RD;
            WR:      state_d = rd_req_i ? RD : IDLE;
            RD:      state_d = wb_req_i ? WR : IDLE;
            default: state_d = IDLE;
        endcase

        // Staging keeps rd_data stable until rd_valid, even if a new read follows.
        if (state_q == RD) begin
            stage_vld_d = 1'b1;
            stage1_d    = (rf_addr1_q == 5'd0) ? 32'd0 : rf_out_1_i;
            stage2_d    = (rf_addr2_q == 5'd0) ? 32'd0 : rf_out_2_i;
        end

        if (stage_vld_q) begin
            rd_data1_d = stage1_q;
            rd_data2_d = stage2_q;
        end

        if (state_d == WR) begin
            wb_ack_d   = 1'b1;
            rf_waddr_d = wb_addr_i;
            rf_din_d   = wb_data_i;
            rf_wr_d    = (wb_addr_i != 5'd0);
        end

        if (state_d == RD) begin
            rd_ack_d   = 1'b1;
            rf_addr1_d = rd_addr1_i;
            rf_addr2_d = rd_addr2_i;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            wb_ack_q    <= 1'b0;
            rd_ack_q    <= 1'b0;
            rf_wr_q     <= 1'b0;
            busy_q      <= 1'b0;
            rf_waddr_q  <= 5'd0;
            rf_addr1_q  <= 5'd0;
            rf_addr2_q  <= 5'd0;
            rf_din_q    <= 32'd0;
            stage_vld_q <= 1'b0;
            stage1_q    <= 32'd0;
            stage2_q    <= 32'd0;
            rd_valid_q  <= 1'b0;
            rd_data1_q  <= 32'd0;
            rd_data2_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            wb_ack_q    <= wb_ack_d;
            rd_ack_q    <= rd_ack_d;
            rf_wr_q     <= rf_wr_d;
            busy_q      <= busy_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_addr1_q  <= rf_addr1_d;
            rf_addr2_q  <= rf_addr2_d;
            rf_din_q    <= rf_din_d;
            stage_vld_q <= stage_vld_d;
            stage1_q    <= stage1_d;
            stage2_q    <= stage2_d;
            rd_valid_q  <= rd_valid_d;
            rd_data1_q  <= rd_data1_d;
            rd_data2_q  <= rd_data2_d;
        end
    end

    assign wb_ack_o   = wb_ack_q;
    assign rd_ack_o   = rd_ack_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_data1_o = rd_data1_q;
    assign rd_data2_o = rd_data2_q;
    assign rf_wr_o    = rf_wr_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_addr1_o = rf_addr1_q;
    assign rf_addr2_o = rf_addr2_q;
    assign rf_din_o   = rf_din_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural negedge register file.
// Each index i of the file starts as 0xA0000000+i so index-0 reads are distinguishable from zero.
module tb_regfile_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        wb_req_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        wb_ack_o;
    logic        rd_req_i;
    logic [4:0]  rd_addr1_i;
    logic [4:0]  rd_addr2_i;
    logic        rd_ack_o;
    logic        rd_valid_o;
    logic [31:0] rd_data1_o;
    logic [31:0] rd_data2_o;
    logic        rf_wr_o;
    logic [4:0]  rf_waddr_o;
    logic [4:0]  rf_addr1_o;
    logic [4:0]  rf_addr2_o;
    logic [31:0] rf_din_o;
    logic [31:0] rf_out_1_i = 32'd0;
    logic [31:0] rf_out_2_i = 32'd0;
    logic        busy_o;

    int n_cmp = 0;
    int n_err = 0;
    int n_wack;
    int n_rack;

    logic [31:0] mem [32];
    logic        mem_init = 1'b0;

    regfile_arbiter dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .wb_req_i   (wb_req_i),
        .wb_addr_i  (wb_addr_i),
        .wb_data_i  (wb_data_i),
        .wb_ack_o   (wb_ack_o),
        .rd_req_i   (rd_req_i),
        .rd_addr1_i (rd_addr1_i),
        .rd_addr2_i (rd_addr2_i),
        .rd_ack_o   (rd_ack_o),
        .rd_valid_o (rd_valid_o),
        .rd_data1_o (rd_data1_o),
        .rd_data2_o (rd_data2_o),
        .rf_wr_o    (rf_wr_o),
        .rf_waddr_o (rf_waddr_o),
        .rf_addr1_o (rf_addr1_o),
        .rf_addr2_o (rf_addr2_o),
        .rf_din_o   (rf_din_o),
        .rf_out_1_i (rf_out_1_i),
        .rf_out_2_i (rf_out_2_i),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hA000_0000 + 32'(i);
            mem_init <= 1'b1;
        end
        if (rf_wr_o) begin
            mem[rf_waddr_o] <= rf_din_o;
        end else begin
            rf_out_1_i <= mem[rf_addr1_o];
            rf_out_2_i <= mem[rf_addr2_o];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] ctl();
        return {busy_o, rf_wr_o, wb_ack_o, rd_ack_o, rd_valid_o};
    endfunction

    initial begin
        rst_n_i = 1'b0; wb_req_i = 1'b0; rd_req_i = 1'b0;
        wb_addr_i = 5'd0; wb_data_i = 32'd0; rd_addr1_i = 5'd0; rd_addr2_i = 5'd0;
        tick(); tick();

        // reset values
        chk("rst_ctl", 32'(ctl()), 32'd0);
        chk("rst_rd_data1", rd_data1_o, 32'd0);
        chk("rst_rd_data2", rd_data2_o, 32'd0);
        chk("rst_rf_din", rf_din_o, 32'd0);
        chk("rst_addrs", {17'd0, rf_waddr_o, rf_addr1_o, rf_addr2_o}, 32'd0);

        // idle for 10 cycles
        rst_n_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_ctl", 32'(ctl()), 32'd0);
        end

        // write 5 <= DEADBEEF, then read it back
        wb_req_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = 32'hDEAD_BEEF;
        tick();
        chk("w5_ctl", 32'(ctl()), 32'b11100);
        chk("w5_waddr", 32'(rf_waddr_o), 32'd5);
        chk("w5_din", rf_din_o, 32'hDEAD_BEEF);
        wb_req_i = 1'b0;
        tick();
        chk("w5_done_ctl", 32'(ctl()), 32'd0);
        rd_req_i = 1'b1; rd_addr1_i = 5'd5; rd_addr2_i = 5'd0;
        tick();
        chk("r5_ctl", 32'(ctl()), 32'b10010);
        chk("r5_addr1", 32'(rf_addr1_o), 32'd5);
        rd_req_i = 1'b0;
        tick();
        chk("r5_wait_ctl", 32'(ctl()), 32'd0);
        tick();
        chk("r5_valid_ctl", 32'(ctl()), 32'b00001);
        chk("r5_data1", rd_data1_o, 32'hDEAD_BEEF);
        chk("r5_data2_idx0", rd_data2_o, 32'd0);
        tick();
        chk("r5_valid_drop", 32'(rd_valid_o), 32'd0);
        chk("r5_data1_hold", rd_data1_o, 32'hDEAD_BEEF);

        // simultaneous requests, same address: WR then RD, read sees new value
        wb_req_i = 1'b1; wb_addr_i = 5'd7; wb_data_i = 32'h1234_5678;
        rd_req_i = 1'b1; rd_addr1_i = 5'd7; rd_addr2_i = 5'd5;
        tick();
        chk("sim_wr_ctl", 32'(ctl()), 32'b11100);
        wb_req_i = 1'b0;
        tick();
        chk("sim_rd_ctl", 32'(ctl()), 32'b10010);
        chk("sim_rd_addr1", 32'(rf_addr1_o), 32'd7);
        rd_req_i = 1'b0;
        tick();
        chk("sim_wait_valid", 32'(rd_valid_o), 32'd0);
        tick();
        chk("sim_valid", 32'(rd_valid_o), 32'd1);
        chk("sim_data1", rd_data1_o, 32'h1234_5678);
        chk("sim_data2", rd_data2_o, 32'hDEAD_BEEF);
        tick();

        // write to index 0 is granted but never reaches the file; read of 0 returns 0
        wb_req_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'hFFFF_FFFF;
        tick();
        chk("w0_ctl", 32'(ctl()), 32'b10100);
        chk("w0_din", rf_din_o, 32'hFFFF_FFFF);
        wb_req_i = 1'b0; rd_req_i = 1'b1; rd_addr1_i = 5'd0; rd_addr2_i = 5'd7;
        tick();
        chk("r0_ctl", 32'(ctl()), 32'b10010);
        rd_req_i = 1'b0;
        tick(); tick();
        chk("r0_valid", 32'(rd_valid_o), 32'd1);
        chk("r0_data1", rd_data1_o, 32'd0);
        chk("r0_data2", rd_data2_o, 32'h1234_5678);
        chk("w0_file_untouched", mem[0], 32'hA000_0000);
        tick();

        // sustained contention alternates WR/RD
        wb_req_i = 1'b1; wb_addr_i = 5'd9; wb_data_i = 32'h0000_0055;
        rd_req_i = 1'b1; rd_addr1_i = 5'd9; rd_addr2_i = 5'd7;
        n_wack = 0; n_rack = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("alt_acks", 32'({wb_ack_o, rd_ack_o}), (i % 2 == 0) ? 32'b10 : 32'b01);
            chk("alt_busy", 32'(busy_o), 32'd1);
            n_wack += int'(wb_ack_o);
            n_rack += int'(rd_ack_o);
        end
        wb_req_i = 1'b0; rd_req_i = 1'b0;
        chk("alt_wack_count", 32'(n_wack), 32'd4);
        chk("alt_rack_count", 32'(n_rack), 32'd4);
        tick();
        chk("alt_tail_valid", 32'(rd_valid_o), 32'd0);
        tick();
        chk("alt_last_valid", 32'(rd_valid_o), 32'd1);
        chk("alt_last_data1", rd_data1_o, 32'h0000_0055);
        tick(); tick();

        // reset during an RD cycle suppresses the pending read
        rd_req_i = 1'b1; rd_addr1_i = 5'd5; rd_addr2_i = 5'd3;
        tick();
        chk("rrst_rack", 32'(rd_ack_o), 32'd1);
        rst_n_i = 1'b0; rd_req_i = 1'b0;
        tick();
        chk("rrst_ctl", 32'(ctl()), 32'd0);
        chk("rrst_data1", rd_data1_o, 32'd0);
        chk("rrst_addrs", {17'd0, rf_waddr_o, rf_addr1_o, rf_addr2_o}, 32'd0);
        chk("rrst_din", rf_din_o, 32'd0);
        rst_n_i = 1'b1;
        tick();
        chk("rrst_no_valid1", 32'(rd_valid_o), 32'd0);
        tick();
        chk("rrst_no_valid2", 32'(rd_valid_o), 32'd0);
        chk("rrst_data_zero", rd_data1_o, 32'd0);

        // reset during a WR cycle: that cycle's write still lands
        wb_req_i = 1'b1; wb_addr_i = 5'd3; wb_data_i = 32'hCAFE_F00D;
        tick();
        chk("wrst_rfwr", 32'(rf_wr_o), 32'd1);
        rst_n_i = 1'b0; wb_req_i = 1'b0;
        tick();
        chk("wrst_ctl", 32'(ctl()), 32'd0);
        chk("wrst_file", mem[3], 32'hCAFE_F00D);

        // requests held across reset release are granted on the first live edge
        wb_req_i = 1'b1; wb_addr_i = 5'd4; wb_data_i = 32'h0000_0077;
        rd_req_i = 1'b1; rd_addr1_i = 5'd4; rd_addr2_i = 5'd0;
        tick();
        chk("hold_in_rst", 32'(ctl()), 32'd0);
        rst_n_i = 1'b1;
        tick();
        chk("hold_wr_ctl", 32'(ctl()), 32'b11100);
        wb_req_i = 1'b0;
        tick();
        chk("hold_rd_ctl", 32'(ctl()), 32'b10010);
        rd_req_i = 1'b0;
        tick(); tick();
        chk("hold_valid", 32'(rd_valid_o), 32'd1);
        chk("hold_data1", rd_data1_o, 32'h0000_0077);
        chk("hold_file_3", mem[3], 32'hCAFE_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
